dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Sequences and shares the single-port word data RAM between two requesters: m0 is the instruction-fetch port (read only) and m1 is the LSU port (read/write, byte/half/word).
- Uses round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse.
- Extracts the byte or halfword lane from the full word on reads.
- The RAM only writes whole words, so the block performs a read-modify-write for sub-word stores.
- Sits between the IFU/LSU and the data RAM. The RAM read is combinational and its write commits on the clk edge when wen is high.

Parameters:
- FIXED_PRIO, default 0: 0 = round-robin between m0 and m1; 1 = m1 always wins a conflict.
- AW, default 32: address width of all address ports.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- m0_req_valid  in  1  fetch request
- m0_req_ready  out  1  fetch request accepted this cycle
- m0_addr  in  AW  fetch address, word aligned
- m0_resp_valid  out  1  one-cycle fetch data pulse
- m0_rdata  out  32  fetch data
- m1_req_valid  in  1  LSU request
- m1_req_ready  out  1  LSU request accepted this cycle
- m1_wen  in  1  1 = store, 0 = load
- m1_len  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- m1_addr  in  AW  byte address
- m1_wdata  in  32  store data, low-aligned
- m1_resp_valid  out  1  one-cycle completion pulse
- m1_resp_err  out  1  misaligned access flag, qualified by m1_resp_valid
- m1_rdata  out  32  load data, zero-extended
- ram_valid  out  1  RAM read enable
- ram_wen  out  1  RAM write enable
- ram_rlen  out  32  RAM read length; always 4
- ram_raddr  out  AW  RAM read address
- ram_waddr  out  AW  RAM write address
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM combinational read data

Behaviour:
Reset:
- While rst_n is low at a posedge: state goes to IDLE, all registered outputs clear to 0, and last_grant is set to m1 so that m0 wins the first conflict.
- ram_wen and ram_valid are also gated combinationally by rst_n, so no RAM write occurs in any cycle where rst_n is low, including a reset mid-RMW.

IDLE state:
- Picks a grant combinationally from the valid requesters:
  - only one valid: that requester;
  - both valid, FIXED_PRIO=0: the requester other than last_grant;
  - both valid, FIXED_PRIO=1: m1.
- mX_req_ready = (state==IDLE) && grant==X. Readiness is never asserted outside IDLE.
- On valid&&ready, the block latches owner, wen, len, addr and wdata, updates last_grant, then decides:
  - misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1 and no RAM activity;
  - otherwise: go to ACCESS.

ACCESS state:
- Drives ram_valid=1, ram_rlen=4, ram_raddr={addr[AW-1:2],2'b00}.
- Load / fetch: captures the lane, zero-extended:
  - byte: selected by addr[1:0];
  - half: selected by addr[1];
  - word: the full word.
  - Then goes to RESP.
- Word store: ram_wen=1, ram_waddr = aligned address, ram_wdata=wdata; go to RESP.
- Sub-word store: captures the old word and goes to MERGE.

MERGE state:
- ram_wen=1 with the merged word: the old word with the addressed byte or half replaced by wdata[7:0] or wdata[15:0]. Go to RESP.

RESP state:
- The owner's resp_valid=1 for exactly one cycle, with rdata held. Go to IDLE.
- rdata is 0 for stores and for err responses.
- Responses have no backpressure; requesters must accept them.

Latency (request accepted at cycle T):
- Load / fetch / word store: resp_valid at T+2.
- Sub-word store: resp_valid at T+3.
- Error: resp_valid at T+1.
- Throughput: at most one transaction in flight. The next acceptance is at the earliest one cycle after RESP.

Boundary conditions:
- Addresses with bit 28 set are forwarded unchanged. The RAM drops those writes; the arbiter still completes the transaction with a normal response.
- The m0 port ignores len and wen; fetches are always word reads. A fetch with addr[1:0]!=0 is read from the aligned word with no error.
- Request signals changing while ready is low have no effect.
- Outputs to the non-owning requester stay 0 throughout a transaction.

Test Plan:
1. Reset, then m0 alone fetches 0x8 with RAM word 0xDEADBEEF at index 2 -> m0_req_ready at T, m0_resp_valid at T+2 with m0_rdata=0xDEADBEEF; m1 outputs stay 0.
2. m0 and m1 both valid every cycle for 4 transactions, FIXED_PRIO=0 -> grants m0,m1,m0,m1, each separated by a RESP cycle; with FIXED_PRIO=1 -> m1 every time.
3. RAM word 0x11223344 at address 0x10; m1 byte store 0xAB to 0x12 -> one ram_wen pulse at T+2 with ram_wdata=0x11AB3344; m1_resp_valid at T+3; a byte load from 0x12 then returns 0x000000AB.
4. m1 half load from 0x12 after a word store of 0xCAFEF00D to 0x10 -> m1_rdata=0x0000CAFE at T+2, resp_err=0.
5. m1 half store to 0x13 -> m1_resp_valid with resp_err=1 at T+1, no ram_wen; a word load from 0x11 -> err=1.
6. Assert rst_n low during MERGE of a byte store -> no ram_wen in that cycle, RAM word unchanged, state IDLE, both resp_valid 0; the next m0 fetch is granted first.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-port word RAM: instruction fetch (m0) and LSU (m1),
// with lane extraction on loads and read-modify-write for sub-word stores.
module dram_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_resp_valid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic          m1_wen,
  input  logic [1:0]    m1_len,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_resp_valid,
  output logic          m1_resp_err,
  output logic [31:0]   m1_rdata,
  output logic          ram_valid,
  output logic          ram_wen,
  output logic [31:0]   ram_rlen,
  output logic [AW-1:0] ram_raddr,
  output logic [AW-1:0] ram_waddr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          lastGrant_q, lastGrant_d;
  logic          owner_q, owner_d;
  logic          wen_q, wen_d;
  logic [1:0]    len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   old_q, old_d;

  logic          grant, anyValid, accept, misaligned, reqWen;
  logic [1:0]    reqLen;
  logic [AW-1:0] reqAddr, alignedAddr;
  logic [31:0]   reqWdata, shifted, laneData, mergeMask, mergedWord;
  logic [4:0]    byteShift, halfShift;

  // Grant is 1 for m1, 0 for m0; m0 is forced to an aligned-word read.
  always_comb begin
    anyValid = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid)
      grant = (FIXED_PRIO != 0) ? 1'b1 : ~lastGrant_q;
    else
      grant = m1_req_valid;
    m0_req_ready = (state_q == IDLE) && anyValid && !grant;
    m1_req_ready = (state_q == IDLE) && anyValid && grant;
    accept       = m0_req_ready | m1_req_ready;
    reqWen       = grant ? m1_wen : 1'b0;
    reqLen       = grant ? m1_len : 2'd2;
    reqAddr      = grant ? m1_addr : m0_addr;
    reqWdata     = grant ? m1_wdata : 32'd0;
    misaligned   = grant && ((reqLen == 2'd1 && reqAddr[0]) ||
                             (reqLen[1] && reqAddr[1:0] != 2'b00));
  end

  always_comb begin
    alignedAddr = {addr_q[AW-1:2], 2'b00};
    byteShift   = {addr_q[1:0], 3'b000};
    halfShift   = {addr_q[1], 4'b0000};
    shifted     = ram_rdata >> byteShift;
    case (len_q)
      2'd0:    laneData = {24'd0, shifted[7:0]};
      2'd1:    laneData = addr_q[1] ? {16'd0, ram_rdata[31:16]} : {16'd0, ram_rdata[15:0]};
      default: laneData = ram_rdata;
    endcase
    if (len_q == 2'd0) begin
      mergeMask  = 32'h0000_00FF << byteShift;
      mergedWord = (old_q & ~mergeMask) | ({24'd0, wdata_q[7:0]} << byteShift);
    end else begin
      mergeMask  = 32'h0000_FFFF << halfShift;
      mergedWord = (old_q & ~mergeMask) | ({16'd0, wdata_q[15:0]} << halfShift);
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    wen_d       = wen_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    old_d       = old_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d     = grant;
          lastGrant_d = grant;
          wen_d       = reqWen;
          len_d       = reqLen;
          addr_d      = reqAddr;
          wdata_d     = reqWdata;
          err_d       = misaligned;
          rdata_d     = 32'd0;
          state_d     = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!wen_q) begin
          rdata_d = laneData;
          state_d = RESP;
        end else if (len_q[1]) begin
          state_d = RESP;
        end else begin
          old_d   = ram_rdata;
          state_d = MERGE;
        end
      end
      MERGE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      wen_q       <= 1'b0;
      len_q       <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      old_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      wen_q       <= wen_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      old_q       <= old_d;
    end
  end

  // RAM strobes are gated by rst_n so a reset mid-RMW never commits a write.
  always_comb begin
    ram_rlen      = 32'd4;
    ram_valid     = rst_n && (state_q == ACCESS);
    ram_wen       = rst_n && ((state_q == ACCESS && wen_q && len_q[1]) || state_q == MERGE);
    ram_raddr     = (state_q == ACCESS) ? alignedAddr : '0;
    ram_waddr     = (state_q == ACCESS || state_q == MERGE) ? alignedAddr : '0;
    if (state_q == MERGE)
      ram_wdata = mergedWord;
    else if (state_q == ACCESS && wen_q)
      ram_wdata = wdata_q;
    else
      ram_wdata = 32'd0;
    m0_resp_valid = (state_q == RESP) && !owner_q;
    m1_resp_valid = (state_q == RESP) && owner_q;
    m0_rdata      = m0_resp_valid ? rdata_q : 32'd0;
    m1_rdata      = m1_resp_valid ? rdata_q : 32'd0;
    m1_resp_err   = m1_resp_valid && err_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them, including response cycle.
module tb_dram_arbiter;

  logic        clk, rst_n;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_err;
  logic [1:0]  m1_len;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_valid, ram_wen;
  logic [31:0] ram_rlen, ram_raddr, ram_waddr, ram_wdata, ram_rdata;

  logic        fpM0Valid, fpM0Ready, fpM0RespValid, fpM1Valid, fpM1Ready, fpM1RespValid, fpM1RespErr;
  logic [31:0] fpM0Rdata, fpM1Rdata, fpRamRlen, fpRamRaddr, fpRamWaddr, fpRamWdata;
  logic        fpRamValid, fpRamWen;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:255];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCnt = 0;
  int          wenCount = 0;
  int          lastWenCycle = 0;
  logic [31:0] lastWenData = 0;
  logic [31:0] lastWenAddr = 0;

  dram_arbiter #(.FIXED_PRIO(0), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_wen(m1_wen),
    .m1_len(m1_len), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_resp_valid(m1_resp_valid), .m1_resp_err(m1_resp_err), .m1_rdata(m1_rdata),
    .ram_valid(ram_valid), .ram_wen(ram_wen), .ram_rlen(ram_rlen),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  dram_arbiter #(.FIXED_PRIO(1), .AW(32)) dutFp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(fpM0Valid), .m0_req_ready(fpM0Ready), .m0_addr(32'h8),
    .m0_resp_valid(fpM0RespValid), .m0_rdata(fpM0Rdata),
    .m1_req_valid(fpM1Valid), .m1_req_ready(fpM1Ready), .m1_wen(1'b0),
    .m1_len(2'd2), .m1_addr(32'h8), .m1_wdata(32'd0),
    .m1_resp_valid(fpM1RespValid), .m1_resp_err(fpM1RespErr), .m1_rdata(fpM1Rdata),
    .ram_valid(fpRamValid), .ram_wen(fpRamWen), .ram_rlen(fpRamRlen),
    .ram_raddr(fpRamRaddr), .ram_waddr(fpRamWaddr), .ram_wdata(fpRamWdata),
    .ram_rdata(32'd0)
  );

  assign ram_rdata = mem[ram_raddr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  // RAM model: sole writer of mem; writes with address bit 28 set are dropped.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    mem[4] = 32'h11223344;
    forever begin
      @(posedge clk);
      if (ram_wen && !ram_waddr[28]) mem[ram_waddr[9:2]] = ram_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: logs RAM writes and pops the scoreboard on every response pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ram_wen) begin
      wenCount++;
      lastWenCycle = cycleCnt;
      lastWenData  = ram_wdata;
      lastWenAddr  = ram_waddr;
    end
    if (rst_n && (m0_resp_valid || m1_resp_valid)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'(m1_resp_valid), 32'(m0_resp_valid));
      end else begin
        e = sb.pop_front();
        checkOutput("resp_onehot", 32'(m0_resp_valid & m1_resp_valid), 32'd0);
        checkOutput("resp_port", 32'(m1_resp_valid), 32'(e.port));
        checkOutput("resp_cycle", cycleCnt, e.cycle);
        if (e.port) begin
          checkOutput("m1_rdata", m1_rdata, e.rdata);
          checkOutput("m1_resp_err", 32'(m1_resp_err), 32'(e.err));
          checkOutput("m0_rdata_idle", m0_rdata, 32'd0);
        end else begin
          checkOutput("m0_rdata", m0_rdata, e.rdata);
          checkOutput("m1_rdata_idle", m1_rdata, 32'd0);
          checkOutput("m1_err_idle", 32'(m1_resp_err), 32'd0);
        end
      end
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m0_ready", 32'(m0_req_ready), 32'd0);
    checkOutput("rst_m1_ready", 32'(m1_req_ready), 32'd0);
    checkOutput("rst_resp", 32'({m0_resp_valid, m1_resp_valid, m1_resp_err}), 32'd0);
    checkOutput("rst_ram", 32'({ram_valid, ram_wen}), 32'd0);
    checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitReady(input logic port, output int t);
    t = -1;
    for (int n = 0; n < 20 && t < 0; n++) begin
      @(negedge clk);
      if (port ? m1_req_ready : m0_req_ready) t = cycleCnt;
    end
    if (t < 0) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drainScoreboard();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic port, input logic wen, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr,
                               input int lat, output int t);
    int start;
    exp_t e;
    @(posedge clk);
    #1;
    if (port) begin
      m1_wen = wen; m1_len = len; m1_addr = addr; m1_wdata = wdata; m1_req_valid = 1'b1;
    end else begin
      m0_addr = addr; m0_req_valid = 1'b1;
    end
    start = cycleCnt;
    waitReady(port, t);
    if (t >= 0) begin
      checkOutput("ready_same_cycle", t, start);
      e.port = port; e.rdata = expRdata; e.err = expErr; e.cycle = t + lat;
      sb.push_back(e);
      @(posedge clk);
    end
    #1 m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    drainScoreboard();
  endtask

  // Both requesters held valid; order[i] is the expected winner of acceptance i.
  task automatic runConflict(input int n, input logic [3:0] order);
    int t, prevT;
    exp_t e;
    logic who;
    prevT = 0;
    @(posedge clk);
    #1 m0_addr = 32'h8;
    m1_wen = 1'b0; m1_len = 2'd2; m1_addr = 32'h8; m1_wdata = 32'd0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      t = -1;
      for (int k = 0; k < 20 && t < 0; k++) begin
        @(negedge clk);
        if (m0_req_ready || m1_req_ready) t = cycleCnt;
      end
      if (t < 0) begin
        checkOutput("conflict_timeout", 32'd0, 32'd1);
        break;
      end
      who = m1_req_ready;
      checkOutput("grant_order", 32'(who), 32'(order[i]));
      checkOutput("grant_onehot", 32'(m0_req_ready & m1_req_ready), 32'd0);
      if (i > 0) checkOutput("grant_spacing", t - prevT, 32'd3);
      prevT = t;
      e.port = who; e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.cycle = t + 2;
      sb.push_back(e);
      @(posedge clk);
    end
    #1 m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    drainScoreboard();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got 0x%08h, expected 0x%08h", cycleCnt, 0);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int t, wenBefore, fpCnt0, fpCnt1, fpResp0, fpResp1;
    rst_n = 1'b0;
    m0_req_valid = 1'b0; m0_addr = 32'd0;
    m1_req_valid = 1'b0; m1_wen = 1'b0; m1_len = 2'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    fpM0Valid = 1'b0; fpM1Valid = 1'b0;
    applyReset();

    $display("[TB] fetch after reset");
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h8, 32'd0, 32'hDEADBEEF, 1'b0, 2, t);

    $display("[TB] fixed priority instance");
    fpCnt0 = 0; fpCnt1 = 0; fpResp0 = 0; fpResp1 = 0;
    @(posedge clk);
    #1 fpM0Valid = 1'b1;
    fpM1Valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      fpCnt0 += int'(fpM0Ready);
      fpCnt1 += int'(fpM1Ready);
      fpResp0 += int'(fpM0RespValid);
      fpResp1 += int'(fpM1RespValid | fpM1RespErr);
    end
    @(posedge clk);
    #1 fpM0Valid = 1'b0;
    fpM1Valid = 1'b0;
    checkOutput("fp_m1_grants", fpCnt1, 32'd4);
    checkOutput("fp_m0_grants", fpCnt0, 32'd0);
    checkOutput("fp_m1_resps", fpResp1, 32'd4);
    checkOutput("fp_m0_resps", fpResp0, 32'd0);
    repeat (4) @(posedge clk);

    $display("[TB] round robin conflict");
    applyReset();
    runConflict(4, 4'b1010);

    $display("[TB] byte store read-modify-write");
    wenBefore = wenCount;
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h12, 32'h0000_00AB, 32'd0, 1'b0, 3, t);
    checkOutput("rmw_wen_count", wenCount - wenBefore, 32'd1);
    checkOutput("rmw_wen_cycle", lastWenCycle, t + 2);
    checkOutput("rmw_wdata", lastWenData, 32'h11AB3344);
    checkOutput("rmw_waddr", lastWenAddr, 32'h10);
    checkOutput("rmw_mem", mem[4], 32'h11AB3344);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h12, 32'd0, 32'h0000_00AB, 1'b0, 2, t);

    $display("[TB] word store and sub-word loads");
    wenBefore = wenCount;
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 32'd0, 1'b0, 2, t);
    checkOutput("word_wen_count", wenCount - wenBefore, 32'd1);
    checkOutput("word_wen_cycle", lastWenCycle, t + 1);
    checkOutput("word_wdata", lastWenData, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h12, 32'd0, 32'h0000CAFE, 1'b0, 2, t);
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h10, 32'd0, 32'h0000F00D, 1'b0, 2, t);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h13, 32'd0, 32'h000000CA, 1'b0, 2, t);

    $display("[TB] misaligned accesses");
    wenBefore = wenCount;
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h13, 32'h0000_1234, 32'd0, 1'b1, 1, t);
    checkOutput("err_no_wen", wenCount - wenBefore, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h11, 32'd0, 32'd0, 1'b1, 1, t);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'hA, 32'd0, 32'hDEADBEEF, 1'b0, 2, t);

    $display("[TB] bit 28 address forwarding");
    wenBefore = wenCount;
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h1000_0010, 32'h12345678, 32'd0, 1'b0, 2, t);
    checkOutput("b28_wen_count", wenCount - wenBefore, 32'd1);
    checkOutput("b28_waddr", lastWenAddr, 32'h1000_0010);
    checkOutput("b28_mem", mem[4], 32'hCAFEF00D);

    $display("[TB] reset during merge");
    wenBefore = wenCount;
    @(posedge clk);
    #1 m1_wen = 1'b1;
    m1_len = 2'd0; m1_addr = 32'h10; m1_wdata = 32'h55; m1_req_valid = 1'b1;
    waitReady(1'b1, t);
    @(posedge clk);
    #1 m1_req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("merge_rst_wen", 32'(ram_wen), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("merge_rst_wen_count", wenCount - wenBefore, 32'd0);
    checkOutput("merge_rst_mem", mem[4], 32'hCAFEF00D);
    checkOutput("merge_rst_resp", 32'({m0_resp_valid, m1_resp_valid}), 32'd0);
    runConflict(2, 4'b0010);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
